pcm_buffer_writer: RTL and testbench

PCM_BUFFER_WRITER -- requirements
Module: pcm_buffer_writer

---
 rtl/pcm_buffer_writer_if.sv | 37 +++
 rtl/pcm_buffer_writer.sv | 211 +++++++++++++++++++++
 tb/tb_pcm_buffer_writer.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pcm_buffer_writer_if.sv
// pcm_buffer_writer_if: sample input and arbiter write-request bundle.
// master = the writer, slave = its environment.
interface pcm_buffer_writer_if;
  logic        pcm_valid;
  logic        pcm_ready;
  logic [31:0] pcm_data;
  logic        pcm_ch;
  logic        req_valid;
  logic        req_ready;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_wen;

  modport master (
    input  pcm_valid,
    input  pcm_data,
    input  pcm_ch,
    input  req_ready,
    output pcm_ready,
    output req_valid,
    output req_addr,
    output req_wdata,
    output req_wen
  );

  modport slave (
    output pcm_valid,
    output pcm_data,
    output pcm_ch,
    output req_ready,
    input  pcm_ready,
    input  req_valid,
    input  req_addr,
    input  req_wdata,
    input  req_wen
  );
endinterface

// File: rtl/pcm_buffer_writer.sv
// pcm_buffer_writer: writes PCM samples into two channel rings.
// Macro PCM_WR_DROP_EN: drop samples for a full channel, count them.
module pcm_buffer_writer #(
  parameter logic [11:0] BASE_CH0 = 12'h000,
  parameter logic [11:0] BASE_CH1 = 12'h400,
  parameter int          CH_DEPTH = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [10:0]         frame_len,
  input  logic [1:0]          frame_release,
  output logic [1:0]          frame_done,
  output logic [10:0]         fill_ch0,
  output logic [10:0]         fill_ch1,
  output logic [15:0]         ovf_cnt,
  pcm_buffer_writer_if.master bus
);

  localparam logic [10:0] FULL = 11'(CH_DEPTH);

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic        ch_q;
  logic [11:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  done_q;

  logic [9:0]  ptr_q   [2];
  logic [10:0] fill_q  [2];
  logic [10:0] cnt_q   [2];
  logic [10:0] len_q   [2];

  logic [9:0]  ptr_d   [2];
  logic [10:0] fill_d  [2];
  logic [10:0] cnt_d   [2];
  logic [10:0] len_d   [2];
  logic [11:0] sum     [2];
  logic [10:0] cur_len [2];
  logic [1:0]  done_d;
  logic [1:0]  inc;

  logic [10:0] len_in;
  logic [11:0] load_addr;
  logic        full_sel;
  logic        ready;
  logic        accept;
  logic        commit;
  logic        load;

  // Clamp the requested frame length to 1..CH_DEPTH.
  always_comb begin
    len_in = frame_len;
    if (frame_len == 11'd0 || frame_len > FULL) begin
      len_in = FULL;
    end
  end

  // A new frame takes the live length; mid-frame uses the latched one.
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      cur_len[c] = (cnt_q[c] == 11'd0) ? len_in : len_q[c];
    end
  end

  assign full_sel = (fill_q[bus.pcm_ch] == FULL);

`ifdef PCM_WR_DROP_EN
  assign ready = rst_n && (state_q == IDLE) && enable;
`else
  assign ready = rst_n && (state_q == IDLE) && enable && !full_sel;
`endif

  assign bus.pcm_ready = ready;
  assign accept        = bus.pcm_valid && ready;
  assign commit        = (state_q == WAIT) && bus.req_ready;
  assign inc[0]        = commit && !ch_q;
  assign inc[1]        = commit && ch_q;

  assign load_addr = bus.pcm_ch
                   ? BASE_CH1 + {2'b00, ptr_q[1]}
                   : BASE_CH0 + {2'b00, ptr_q[0]};

  // Request FSM: next state and handshake outputs.
  always_comb begin
    state_d       = state_q;
    load          = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_wen   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept && !full_sel) begin
          load    = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        bus.req_valid = 1'b1;
        bus.req_wen   = 1'b1;
        if (bus.req_ready) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // Per-channel pointer, fill and frame bookkeeping.
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      sum[c]    = {1'b0, fill_q[c]} + {11'd0, inc[c]};
      ptr_d[c]  = ptr_q[c] + {9'd0, inc[c]};
      cnt_d[c]  = cnt_q[c];
      len_d[c]  = len_q[c];
      done_d[c] = 1'b0;
      fill_d[c] = sum[c][10:0];
      if (frame_release[c]) begin
        if (sum[c] > {1'b0, cur_len[c]}) begin
          fill_d[c] = 11'(sum[c] - {1'b0, cur_len[c]});
        end else begin
          fill_d[c] = 11'd0;
        end
      end
      if (inc[c]) begin
        if (cnt_q[c] == 11'd0) begin
          len_d[c] = len_in;
        end
        if (cnt_q[c] + 11'd1 == cur_len[c]) begin
          cnt_d[c]  = 11'd0;
          done_d[c] = 1'b1;
        end else begin
          cnt_d[c] = cnt_q[c] + 11'd1;
        end
      end
    end
  end

  // State register; reset discards any pending request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture the accepted sample and its target address.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ch_q    <= 1'b0;
      addr_q  <= 12'h000;
      wdata_q <= 32'h0;
    end else if (load) begin
      ch_q    <= bus.pcm_ch;
      addr_q  <= load_addr;
      wdata_q <= bus.pcm_data;
    end
  end

  // Channel state registers and the registered frame_done pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done_q <= 2'b00;
      for (int c = 0; c < 2; c++) begin
        ptr_q[c]  <= 10'd0;
        fill_q[c] <= 11'd0;
        cnt_q[c]  <= 11'd0;
        len_q[c]  <= FULL;
      end
    end else begin
      done_q <= done_d;
      for (int c = 0; c < 2; c++) begin
        ptr_q[c]  <= ptr_d[c];
        fill_q[c] <= fill_d[c];
        cnt_q[c]  <= cnt_d[c];
        len_q[c]  <= len_d[c];
      end
    end
  end

`ifdef PCM_WR_DROP_EN
  logic        drop;
  logic [15:0] ovf_q;

  assign drop = accept && full_sel;

  // Count samples discarded for a full channel, saturating.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 16'h0000;
    end else if (drop && ovf_q != 16'hFFFF) begin
      ovf_q <= ovf_q + 16'h0001;
    end
  end

  assign ovf_cnt = ovf_q;
`else
  assign ovf_cnt = 16'h0000;
`endif

  assign bus.req_addr  = addr_q;
  assign bus.req_wdata = wdata_q;
  assign frame_done    = done_q;
  assign fill_ch0      = fill_q[0];
  assign fill_ch1      = fill_q[1];

endmodule

// File: tb/tb_pcm_buffer_writer.sv
// tb_pcm_buffer_writer: directed vector bench for pcm_buffer_writer.
// Honours PCM_WR_DROP_EN for the full-channel case.
module tb_pcm_buffer_writer;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [10:0] frame_len;
  logic [1:0]  frame_release;
  logic [1:0]  frame_done;
  logic [10:0] fill_ch0;
  logic [10:0] fill_ch1;
  logic [15:0] ovf_cnt;

  pcm_buffer_writer_if bus();

  pcm_buffer_writer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .frame_len     (frame_len),
    .frame_release (frame_release),
    .frame_done    (frame_done),
    .fill_ch0      (fill_ch0),
    .fill_ch1      (fill_ch1),
    .ovf_cnt       (ovf_cnt),
    .bus           (bus)
  );

  typedef struct {
    logic        ch;
    logic [31:0] data;
    int          hold;
    logic [11:0] addr;
    logic [10:0] f0;
    logic [10:0] f1;
    bit          en_off;
  } vec_t;

  vec_t v [7];
  int   n_cmp;
  int   n_bad;
  int   fd0;
  int   fd1;
  int   fd0_base;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_done[0]) fd0++;
    if (frame_done[1]) fd1++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit hit, required reaching summary");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic send(input logic ch, input logic [31:0] d,
                      input int hold, input logic [11:0] ea,
                      input logic [1:0] rel, input bit en_off);
    int t;
    @(negedge clk);
    bus.pcm_valid = 1'b1;
    bus.pcm_ch    = ch;
    bus.pcm_data  = d;
    #1;
    t = 0;
    while (!bus.pcm_ready && t < 20) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk("accept", {31'd0, bus.pcm_ready}, 32'd1);
    if (!bus.pcm_ready) begin
      bus.pcm_valid = 1'b0;
      return;
    end
    @(negedge clk);
    bus.pcm_valid = 1'b0;
    if (en_off) enable = 1'b0;
    for (int i = 0; i <= hold; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      chk("req_valid", {31'd0, bus.req_valid}, 32'd1);
      chk("req_wen", {31'd0, bus.req_wen}, 32'd1);
      chk("req_addr", {20'd0, bus.req_addr}, {20'd0, ea});
      chk("req_wdata", bus.req_wdata, d);
      chk("ready_wait", {31'd0, bus.pcm_ready}, 32'd0);
    end
    bus.req_ready = 1'b1;
    frame_release = rel;
    @(negedge clk);
    bus.req_ready = 1'b0;
    frame_release = 2'b00;
    #1;
    chk("valid_after", {31'd0, bus.req_valid}, 32'd0);
    if (en_off) enable = 1'b1;
  endtask

  task automatic release_ch(input logic [1:0] m);
    @(negedge clk);
    frame_release = m;
    @(negedge clk);
    frame_release = 2'b00;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    fd0   = 0;
    fd1   = 0;
    rst_n = 1'b0;
    enable = 1'b1;
    frame_len = 11'd4;
    frame_release = 2'b00;
    bus.pcm_valid = 1'b0;
    bus.pcm_ch = 1'b0;
    bus.pcm_data = 32'h0;
    bus.req_ready = 1'b0;

    v[0] = '{1'b0, 32'hA0, 1, 12'h000, 11'd1, 11'd0, 1'b0};
    v[1] = '{1'b0, 32'hA1, 1, 12'h001, 11'd2, 11'd0, 1'b0};
    v[2] = '{1'b0, 32'hA2, 1, 12'h002, 11'd3, 11'd0, 1'b0};
    v[3] = '{1'b0, 32'hA3, 1, 12'h003, 11'd4, 11'd0, 1'b0};
    v[4] = '{1'b1, 32'hB0, 5, 12'h400, 11'd4, 11'd1, 1'b0};
    v[5] = '{1'b1, 32'hB1, 0, 12'h401, 11'd4, 11'd2, 1'b0};
    v[6] = '{1'b0, 32'hA4, 0, 12'h004, 11'd5, 11'd2, 1'b0};

    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid", {31'd0, bus.req_valid}, 32'd0);
    chk("rst_wen", {31'd0, bus.req_wen}, 32'd0);
    chk("rst_addr", {20'd0, bus.req_addr}, 32'd0);
    chk("rst_wdata", bus.req_wdata, 32'd0);
    chk("rst_ready", {31'd0, bus.pcm_ready}, 32'd0);
    chk("rst_fdone", {30'd0, frame_done}, 32'd0);
    chk("rst_fill0", {21'd0, fill_ch0}, 32'd0);
    chk("rst_fill1", {21'd0, fill_ch1}, 32'd0);
    chk("rst_ovf", {16'd0, ovf_cnt}, 32'd0);
    rst_n = 1'b1;

    for (int k = 0; k < 7; k++) begin
      send(v[k].ch, v[k].data, v[k].hold, v[k].addr, 2'b00, v[k].en_off);
      chk("vec_fill0", {21'd0, fill_ch0}, {21'd0, v[k].f0});
      chk("vec_fill1", {21'd0, fill_ch1}, {21'd0, v[k].f1});
      if (k == 3) chk("fd0_frame", fd0, 1);
    end
    chk("fd0_once", fd0, 1);
    chk("fd1_none", fd1, 0);

    release_ch(2'b01);
    chk("rel_fill0", {21'd0, fill_ch0}, 32'd1);
    release_ch(2'b10);
    chk("rel_sat1", {21'd0, fill_ch1}, 32'd0);

    send(1'b1, 32'hB2, 2, 12'h402, 2'b00, 1'b1);
    chk("enoff_fill1", {21'd0, fill_ch1}, 32'd1);

    @(negedge clk);
    bus.pcm_valid = 1'b1;
    bus.pcm_ch = 1'b0;
    bus.pcm_data = 32'hDEAD;
    #1;
    chk("rw_accept", {31'd0, bus.pcm_ready}, 32'd1);
    @(negedge clk);
    bus.pcm_valid = 1'b0;
    #1;
    chk("rw_valid", {31'd0, bus.req_valid}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    chk("rw_valid0", {31'd0, bus.req_valid}, 32'd0);
    chk("rw_wen0", {31'd0, bus.req_wen}, 32'd0);
    chk("rw_addr0", {20'd0, bus.req_addr}, 32'd0);
    chk("rw_wdata0", bus.req_wdata, 32'd0);
    chk("rw_ready0", {31'd0, bus.pcm_ready}, 32'd0);
    chk("rw_fill0", {21'd0, fill_ch0}, 32'd0);
    chk("rw_fill1", {21'd0, fill_ch1}, 32'd0);
    rst_n = 1'b1;
    frame_len = 11'd16;
    send(1'b0, 32'hC0, 0, 12'h000, 2'b00, 1'b0);
    chk("co_fill_a", {21'd0, fill_ch0}, 32'd1);
    send(1'b0, 32'hC1, 1, 12'h001, 2'b01, 1'b0);
    chk("co_fill_b", {21'd0, fill_ch0}, 32'd0);

    @(negedge clk);
    rst_n = 1'b0;
    frame_len = 11'd0;
    @(negedge clk);
    rst_n = 1'b1;
    fd0_base = fd0;
    for (int i = 0; i < 1024; i++) begin
      send(1'b0, 32'(i), 0, 12'(i), 2'b00, 1'b0);
    end
    chk("full_fill", {21'd0, fill_ch0}, 32'd1024);
    chk("full_fd0", fd0 - fd0_base, 1);

`ifdef PCM_WR_DROP_EN
    @(negedge clk);
    bus.pcm_valid = 1'b1;
    bus.pcm_ch = 1'b0;
    bus.pcm_data = 32'hBAD;
    #1;
    chk("drop_ready", {31'd0, bus.pcm_ready}, 32'd1);
    @(negedge clk);
    bus.pcm_valid = 1'b0;
    #1;
    chk("drop_noreq", {31'd0, bus.req_valid}, 32'd0);
    chk("drop_ovf", {16'd0, ovf_cnt}, 32'd1);
    chk("drop_fill", {21'd0, fill_ch0}, 32'd1024);
`else
    @(negedge clk);
    bus.pcm_valid = 1'b1;
    bus.pcm_ch = 1'b0;
    bus.pcm_data = 32'hBAD;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_ready", {31'd0, bus.pcm_ready}, 32'd0);
      @(negedge clk);
    end
    #1;
    chk("bp_noreq", {31'd0, bus.req_valid}, 32'd0);
    bus.pcm_ch = 1'b1;
    #1;
    chk("bp_ch1_ready", {31'd0, bus.pcm_ready}, 32'd1);
    bus.pcm_valid = 1'b0;
    chk("bp_ovf", {16'd0, ovf_cnt}, 32'd0);
    chk("bp_fill", {21'd0, fill_ch0}, 32'd1024);
`endif

    release_ch(2'b01);
    chk("wrap_rel", {21'd0, fill_ch0}, 32'd0);
    send(1'b0, 32'h55, 0, 12'h000, 2'b00, 1'b0);
    chk("wrap_fill", {21'd0, fill_ch0}, 32'd1);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
